// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory req/ack channel, decoded IR fields and
// controller retire/next-PC inputs. master = fetch unit, slave = memory/controller.
interface instr_fetch_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [25:0] target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_done;
  logic        jump;
  logic        jr;
  logic        beq;
  logic        bne;
  logic [31:0] jr_addr;
  logic        zero;
  logic        align_fault;

  modport master (
    output mem_req, mem_addr, instr_valid, opcode, rs, rt, rd, funct,
           imm16, target, pc, pc_plus4, align_fault,
    input  mem_ack, mem_rdata, instr_done, jump, jr, beq, bne, jr_addr, zero
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, opcode, rs, rt, rd, funct,
           imm16, target, pc, pc_plus4, align_fault,
    output mem_ack, mem_rdata, instr_done, jump, jr, beq, bne, jr_addr, zero
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Multicycle fetch stage: owns the PC, fetches over req/ack and holds the IR
// until retirement. Optional misaligned-next-PC trap under FETCH_ALIGN_CHECK_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    instr_fetch_unit_if.master      bus,
    output logic [1:0]              o_dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic [1:0] S_FAULT = 2'd3;
`endif

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_off;
    logic        w_take_br;
    logic [31:0] w_next_pc;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_br_off   = {{14{r_ir[15]}}, r_ir[15:0], 2'b00};
    assign w_take_br  = (bus.beq & bus.zero) | (bus.bne & ~bus.zero);

    always_comb begin
        w_next_pc = w_pc_plus4;
        if (bus.jr)
            w_next_pc = bus.jr_addr;
        else if (bus.jump)
            w_next_pc = {w_pc_plus4[31:28], r_ir[25:0], 2'b00};
        else if (w_take_br)
            w_next_pc = w_pc_plus4 + w_br_off;
    end

    // Handshake: mem_req stays high with mem_addr stable until a cycle where
    // mem_ack is also high; that edge transfers mem_rdata. Ack with req low is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_ir    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE:  r_state <= S_FETCH;
                S_FETCH: begin
                    if (bus.mem_ack) begin
                        r_ir    <= bus.mem_rdata;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.instr_done) begin
                        r_pc <= w_next_pc;
`ifdef FETCH_ALIGN_CHECK_EN
                        r_state <= (w_next_pc[1:0] != 2'b00) ? S_FAULT : S_FETCH;
`else
                        r_state <= S_FETCH;
`endif
                    end
                end
`ifdef FETCH_ALIGN_CHECK_EN
                S_FAULT: r_state <= S_FAULT;
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_req     = (r_state == S_FETCH);
    assign bus.mem_addr    = r_pc;
    assign bus.instr_valid = (r_state == S_HOLD);
    assign bus.opcode      = r_ir[31:26];
    assign bus.rs          = r_ir[25:21];
    assign bus.rt          = r_ir[20:16];
    assign bus.rd          = r_ir[15:11];
    assign bus.funct       = r_ir[5:0];
    assign bus.imm16       = r_ir[15:0];
    assign bus.target      = r_ir[25:0];
    assign bus.pc          = r_pc;
    assign bus.pc_plus4    = w_pc_plus4;
`ifdef FETCH_ALIGN_CHECK_EN
    assign bus.align_fault = (r_state == S_FAULT);
`else
    assign bus.align_fault = 1'b0;
`endif
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a
// randomized instruction stream checked against an arithmetic next-PC model.
module tb_instr_fetch_unit;
  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         n_cmp;
  int         n_fail;
  logic [31:0] exp_q[$];

  instr_fetch_unit_if bus();

  instr_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] w,
                                             input bit f_jr, input bit f_jump, input bit f_beq,
                                             input bit f_bne, input bit f_zero,
                                             input logic [31:0] ja);
    logic [31:0] seq;
    logic [15:0] imm;
    int          off;
    seq = pc + 32'd4;
    imm = w[15:0];
    off = int'($signed(imm));
    if (f_jr) return ja;
    if (f_jump) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 32'd4);
    if ((f_beq && f_zero) || (f_bne && !f_zero)) return seq + 32'(off * 4);
    return seq;
  endfunction

  // driver tasks: all begin and end just after a falling edge
  task automatic drive_idle();
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0; bus.instr_done = 1'b0;
    bus.jump = 1'b0; bus.jr = 1'b0; bus.beq = 1'b0; bus.bne = 1'b0;
    bus.jr_addr = 32'd0; bus.zero = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive_idle();
    repeat (3) @(negedge clk);
  endtask

  task automatic fetch_word(input logic [31:0] word, input int lat,
                            output logic [31:0] addr, output bit ok);
    int n;
    n = 0;
    while (!bus.mem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = bus.mem_req;
    addr = bus.mem_addr;
    repeat (lat) @(negedge clk);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = word;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    bus.mem_rdata = $urandom;
  endtask

  task automatic retire(input bit f_jr, input bit f_jump, input bit f_beq, input bit f_bne,
                        input bit f_zero, input logic [31:0] ja);
    bus.jr = f_jr; bus.jump = f_jump; bus.beq = f_beq; bus.bne = f_bne;
    bus.zero = f_zero; bus.jr_addr = ja; bus.instr_done = 1'b1;
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if (bus.mem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.align_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got req=%b valid=%b fault=%b exp 0/0/0",
               bus.mem_req, bus.instr_valid, bus.align_fault);
    end
    n_cmp++;
    if (bus.pc !== 32'h0 || bus.mem_addr !== 32'h0 || bus.pc_plus4 !== 32'h4) begin
      n_fail++;
      $display("FAIL reset_pc: got pc=%h addr=%h pc4=%h exp 0/0/4", bus.pc, bus.mem_addr, bus.pc_plus4);
    end
    n_cmp++;
    if (bus.opcode !== 6'h0 || bus.target !== 26'h0 || bus.funct !== 6'h0 || bus.rd !== 5'h0) begin
      n_fail++;
      $display("FAIL reset_ir: got opcode=%h target=%h exp 0", bus.opcode, bus.target);
    end
  endtask

  task automatic test_basic_fetch();
    logic [31:0] a;
    bit ok;
    rst_n = 1'b1;
    n_cmp++;
    if (bus.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle_req: got %b exp 0", bus.mem_req);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL basic_first_req: got req=%b addr=%h exp 1/0", bus.mem_req, bus.mem_addr);
    end
    fetch_word(32'h2008_0005, 2, a, ok);
    n_cmp++;
    if (!ok || a !== 32'h0) begin
      n_fail++;
      $display("FAIL basic_fetch0: got ok=%b addr=%h exp 1/0", ok, a);
    end
    n_cmp++;
    if (bus.instr_valid !== 1'b1 || bus.mem_req !== 1'b0 || bus.opcode !== 6'h08 ||
        bus.rt !== 5'd8 || bus.rs !== 5'd0 || bus.imm16 !== 16'h0005) begin
      n_fail++;
      $display("FAIL basic_fields: got v=%b req=%b op=%h rs=%h rt=%h imm=%h exp 1/0/08/0/8/0005",
               bus.instr_valid, bus.mem_req, bus.opcode, bus.rs, bus.rt, bus.imm16);
    end
    retire(0, 0, 0, 0, 0, 32'h0);
    n_cmp++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h4 || bus.instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_next: got req=%b addr=%h v=%b exp 1/4/0", bus.mem_req, bus.mem_addr, bus.instr_valid);
    end
    fetch_word(32'h0000_0000, 2, a, ok);
    n_cmp++;
    if (!ok || a !== 32'h4 || bus.opcode !== 6'h0 || bus.pc !== 32'h4) begin
      n_fail++;
      $display("FAIL basic_fetch1: got ok=%b addr=%h op=%h pc=%h exp 1/4/0/4", ok, a, bus.opcode, bus.pc);
    end
  endtask

  task automatic test_branch();
    logic [31:0] a;
    bit ok;
    retire(1, 0, 0, 0, 0, 32'h10);
    fetch_word(32'h1000_FFFF, 0, a, ok);
    retire(0, 0, 1, 0, 1, 32'h0);
    n_cmp++;
    if (bus.mem_addr !== 32'h10 || bus.mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL beq_taken: got addr=%h req=%b exp 10/1", bus.mem_addr, bus.mem_req);
    end
    fetch_word(32'h1000_FFFF, 1, a, ok);
    retire(0, 0, 1, 0, 0, 32'h0);
    n_cmp++;
    if (bus.mem_addr !== 32'h14) begin
      n_fail++;
      $display("FAIL beq_not_taken: got addr=%h exp 14", bus.mem_addr);
    end
  endtask

  task automatic test_jump();
    logic [31:0] a;
    bit ok;
    fetch_word(32'h0, 0, a, ok);
    retire(1, 0, 0, 0, 0, 32'h1000_0000);
    fetch_word(32'h0800_0040, 1, a, ok);
    retire(0, 1, 0, 0, 0, 32'h0);
    n_cmp++;
    if (bus.mem_addr !== 32'h1000_0100) begin
      n_fail++;
      $display("FAIL jump_target: got addr=%h exp 10000100", bus.mem_addr);
    end
    fetch_word(32'h0800_0040, 0, a, ok);
    retire(1, 1, 0, 0, 0, 32'h200);
    n_cmp++;
    if (bus.mem_addr !== 32'h200) begin
      n_fail++;
      $display("FAIL jr_priority: got addr=%h exp 200", bus.mem_addr);
    end
  endtask

  task automatic test_wrap_and_stray();
    logic [31:0] a;
    bit ok;
    fetch_word(32'h0, 0, a, ok);
    retire(1, 0, 0, 0, 0, 32'hFFFF_FFFC);
    fetch_word(32'h1234_5678, 0, a, ok);
    n_cmp++;
    if (bus.pc_plus4 !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_pc4: got %h exp 0", bus.pc_plus4);
    end
    repeat (3) begin
      bus.mem_ack = 1'b1;
      bus.mem_rdata = 32'hFFFF_0000;
      @(negedge clk);
    end
    bus.mem_ack = 1'b0;
    n_cmp++;
    if (bus.target !== 26'h234_5678 || bus.opcode !== 6'h04 || bus.pc !== 32'hFFFF_FFFC ||
        bus.instr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stray_ack: got op=%h target=%h pc=%h v=%b exp 04/2345678/fffffffc/1",
               bus.opcode, bus.target, bus.pc, bus.instr_valid);
    end
    retire(0, 0, 0, 0, 0, 32'h0);
    n_cmp++;
    if (bus.mem_addr !== 32'h0 || bus.mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_addr: got addr=%h req=%b exp 0/1", bus.mem_addr, bus.mem_req);
    end
    repeat (3) begin
      bus.instr_done = 1'b1; bus.jr = 1'b1; bus.jr_addr = 32'h0000_0800;
      @(negedge clk);
    end
    drive_idle();
    n_cmp++;
    if (bus.mem_addr !== 32'h0 || bus.mem_req !== 1'b1 || bus.target !== 26'h234_5678) begin
      n_fail++;
      $display("FAIL stray_done: got addr=%h req=%b target=%h exp 0/1/2345678",
               bus.mem_addr, bus.mem_req, bus.target);
    end
  endtask

  task automatic test_reset_mid_fetch();
    logic [31:0] a;
    bit ok;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.mem_req !== 1'b0 || bus.pc !== 32'h0 || bus.opcode !== 6'h0) begin
      n_fail++;
      $display("FAIL rst_async: got req=%b pc=%h op=%h exp 0/0/0", bus.mem_req, bus.pc, bus.opcode);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.target !== 26'h0 || bus.opcode !== 6'h0 || bus.instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ack_dropped: got op=%h target=%h v=%b exp 0/0/0",
               bus.opcode, bus.target, bus.instr_valid);
    end
    drive_idle();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_refetch: got req=%b addr=%h exp 1/0", bus.mem_req, bus.mem_addr);
    end
    fetch_word(32'h0, 0, a, ok);
  endtask

  task automatic test_align();
    bit bad;
    retire(1, 0, 0, 0, 0, 32'h102);
`ifdef FETCH_ALIGN_CHECK_EN
    bad = 1'b0;
    repeat (20) begin
      if (bus.mem_req !== 1'b0 || bus.align_fault !== 1'b1 || bus.instr_valid !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (bad || bus.pc !== 32'h102) begin
      n_fail++;
      $display("FAIL align_fault: got req=%b fault=%b pc=%h exp 0/1/102 for 20 cycles",
               bus.mem_req, bus.align_fault, bus.pc);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.align_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL align_clear: got %b exp 0", bus.align_fault);
    end
`else
    bad = 1'b0;
    n_cmp++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h102 || bus.align_fault !== 1'b0 || bad) begin
      n_fail++;
      $display("FAIL align_nocheck: got req=%b addr=%h fault=%b exp 1/102/0",
               bus.mem_req, bus.mem_addr, bus.align_fault);
    end
`endif
    apply_reset();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] a, w, ja, e, mpc;
    bit ok, f_jr, f_jump, f_beq, f_bne, f_zero;
    int sel;
    exp_q.delete();
    exp_q.push_back(32'h0);
    for (int i = 0; i < 40; i++) begin
      w = $urandom;
      fetch_word(w, $urandom_range(0, 3), a, ok);
      e = exp_q.pop_front();
      mpc = e;
      n_cmp++;
      if (!ok || a !== e) begin
        n_fail++;
        $display("FAIL rand_addr[%0d]: got ok=%b addr=%h exp %h", i, ok, a, e);
      end
      n_cmp++;
      if (bus.opcode !== 6'(w >> 26) || bus.rs !== 5'((w >> 21) % 32) || bus.rt !== 5'((w >> 16) % 32) ||
          bus.rd !== 5'((w >> 11) % 32) || bus.funct !== 6'(w % 64) || bus.imm16 !== 16'(w % 65536) ||
          bus.pc_plus4 !== mpc + 32'd4 || bus.instr_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_fields[%0d]: got op=%h rs=%h rt=%h rd=%h fn=%h pc4=%h word %h pc %h",
                 i, bus.opcode, bus.rs, bus.rt, bus.rd, bus.funct, bus.pc_plus4, w, mpc);
      end
      sel = $urandom_range(0, 4);
      f_jr = (sel == 1); f_jump = (sel == 2) || ($urandom_range(0, 3) == 0);
      f_beq = (sel == 3); f_bne = (sel == 4); f_zero = $urandom_range(0, 1);
      ja = $urandom & 32'hFFFF_FFFC;
      exp_q.push_back(model_next(mpc, w, f_jr, f_jump, f_beq, f_bne, f_zero, ja));
      retire(f_jr, f_jump, f_beq, f_bne, f_zero, ja);
    end
    n_cmp++;
    if (bus.mem_addr !== exp_q[0]) begin
      n_fail++;
      $display("FAIL rand_last: got addr=%h exp %h", bus.mem_addr, exp_q[0]);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    drive_idle();
    @(negedge clk);
    test_reset();
    test_basic_fetch();
    test_branch();
    test_jump();
    test_wrap_and_stray();
    test_reset_mid_fetch();
    test_align();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
